// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and NOP encoding for the fetch stage
package fetch_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_INSTR_W = 16;

    localparam logic [5:0]  NOP_OPCODE = 6'b111000;
    localparam logic [15:0] NOP_WORD   = {NOP_OPCODE, 10'b0};

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used as the prefetch queue
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = DEF_INSTR_W + DEF_ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [WIDTH-1:0]             head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - PC, credit-based issue to 1-cycle imem, prefetch queue, redirect
module ifetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_dir,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [ADDR_W-1:0]  dec_pc_next
);

    localparam int EW = INSTR_W + ADDR_W;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [ADDR_W-1:0]  hold_pc;
    logic [ADDR_W-1:0]  hold_pc_next;

    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [EW-1:0]      fifo_head;
    logic               push;
    logic               pop;
    logic [CW:0]        occupancy;
    logic               issue;

    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic [ADDR_W-1:0]  head_pc_next;

    // Entries carry the successor PC; the head PC is recovered by subtracting one.
    assign head_instr   = fifo_head[EW-1:ADDR_W];
    assign head_pc_next = fifo_head[ADDR_W-1:0];
    assign head_pc      = head_pc_next - ADDR_W'(1);

    // Credit: a request is only issued if its response is guaranteed a slot.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign issue     = !reset && !br_taken && (occupancy < (CW+1)'(DEPTH));

    assign mem_req   = issue;
    assign mem_addr  = pc;

    assign push      = inflight && !br_taken;
    assign pop       = dec_valid && dec_ready;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (br_taken),
        .push      (push),
        .push_data ({mem_rdata, inflight_pc + ADDR_W'(1)}),
        .pop       (pop),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            hold_pc      <= '0;
            hold_pc_next <= '0;
        end else begin
            if (!fifo_empty) begin
                hold_pc      <= head_pc;
                hold_pc_next <= head_pc_next;
            end
            if (br_taken) begin
                pc       <= br_dir;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= pc + ADDR_W'(1);
                    inflight_pc <= pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            assert (!fifo_full || dec_ready);
        end
    end

    // Empty queue shows a NOP while the PC outputs keep the last head seen.
    assign dec_valid   = !fifo_empty;
    assign dec_instr   = fifo_empty ? INSTR_W'(NOP_WORD) : head_instr;
    assign dec_pc      = fifo_empty ? hold_pc      : head_pc;
    assign dec_pc_next = fifo_empty ? hold_pc_next : head_pc_next;

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised next-generation instruction fetch stage.
- Holds the PC and issues requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a DEPTH-entry prefetch queue and presents them to decode over a valid/ready handshake.
- Adds decode backpressure, branch redirect with queue flush and in-flight squash, and a configurable reset vector.

Parameters:
- ADDR_W, 10, instruction address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 16, instruction word width.
- DEPTH, 4, prefetch queue entries. Minimum 2; full throughput requires at least 3.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  reset (synchronous, active-high)
- br_taken  in  1  redirect request from execute
- br_dir  in  ADDR_W  redirect target
- mem_req  out  1  memory read request this cycle
- mem_addr  out  ADDR_W  read address (equals pc)
- mem_rdata  in  INSTR_W  read data, valid the cycle after mem_req
- dec_valid  out  1  queue head is valid
- dec_ready  in  1  decode accepts head this cycle
- dec_instr  out  INSTR_W  head instruction; NOP_WORD when empty
- dec_pc  out  ADDR_W  address of head instruction
- dec_pc_next  out  ADDR_W  dec_pc+1, wrapped

Behaviour:
- Reset, synchronous: pc=RESET_PC; queue count=0; inflight=0. Outputs: mem_req=0, dec_valid=0, dec_instr=NOP_WORD, dec_pc=0, dec_pc_next=0.
- Reset takes priority over everything, including in mid-operation. Queue contents and any in-flight response are discarded.
- Issue rule:
  - mem_req = !reset && !br_taken && (count + inflight < DEPTH).
  - The rule uses registered state only; there is no combinational path from dec_ready.
  - On mem_req, pc <= pc+1 (wraps 2^ADDR_W-1 -> 0). inflight <= 1 and inflight_pc <= pc.
  - Otherwise inflight <= 0.
- Response: when inflight=1, mem_rdata and inflight_pc+1 are pushed into the queue at the end of that cycle.
- Pop: dec_valid && dec_ready removes the head at the clock edge.
- Simultaneous push and pop: count is unchanged and both actions occur.
- Full/empty:
  - The credit rule guarantees no push when full; an overflow is an assertion failure.
  - Empty gives dec_valid=0 and dec_instr=NOP_WORD.
  - dec_pc and dec_pc_next hold their last values while empty.
- Redirect (br_taken=1 in cycle T), priority over push and pop:
  - Queue flushed (count=0, pointers reset).
  - In-flight response arriving in T is dropped.
  - pc <= br_dir; no request is issued in T.
  - A pop in T is considered consumed; the decoder is responsible for squashing it.
- Redirect latency: req(br_dir) in T+1, data in T+2, dec_valid=1 with dec_pc=br_dir in T+3.
- Reset latency: first req in the first cycle after reset deasserts (cycle 0); dec_valid in cycle 2.
- Steady state, DEPTH>=3 and dec_ready=1: one instruction per cycle, in program order.
- Stall: dec_ready=0 holds the head stable. The queue fills to DEPTH, then mem_req=0 until a pop.
- Ordering: instructions leave in issue order; no duplicates, no skips except at a redirect.

Decomposition:
- Shared package fetch_pkg holds: ADDR_W/INSTR_W defaults, NOP opcode, and NOP_WORD = {NOP opcode, 10'b0}.
- Sub-module fetch_fifo: synchronous FIFO with flush input.
  - Parameters: WIDTH=INSTR_W+ADDR_W, DEPTH.
  - Outputs: count, full, empty, head.
- The top level holds the PC, inflight/credit logic and redirect control.

Test Plan:
- Straight line: reset with RESET_PC=0; ROM[i]=i; dec_ready=1 -> dec_valid from cycle 2. dec_instr 0,1,2,... one per cycle, with dec_pc=i and dec_pc_next=i+1.
- Backpressure: dec_ready=0 for 10 cycles from cycle 4 -> head frozen, count reaches 4, mem_req=0 after fill. Release -> sequence resumes, no loss or duplication.
- Redirect with in-flight: br_taken=1, br_dir=0x26 while count=3 and inflight=1 -> queue empty in T+1. First valid dec_pc=0x26 in T+3; the dropped response never appears.
- Redirect while full and stalled: dec_ready=0, queue full, br_taken=1 -> flush; the new stream starts at br_dir with correct latency.
- Wrap-around: RESET_PC=1022 -> dec_pc 1022, 1023, 0, 1, and dec_pc_next=0 for the 1023 entry.
- Reset mid-stream: reset asserted for 1 cycle with count=2 and inflight=1 -> next cycle dec_valid=0 and mem_addr=RESET_PC; no stale instruction is ever delivered.
